// File: rtl/neuron_mac_q88.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac_q88
//  Function : Streaming signed Q8.8 dot product with bias, round-half-up and
//             16-bit saturation; one result per vector, held until accepted.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_mac_q88 #(
   parameter int FRAC    = 8,
   parameter int ACC_W   = 40,
   parameter int MAX_LEN = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_x,
   input  logic [15:0] in_w,
   input  logic        in_last,
   input  logic [15:0] bias,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_y,
   output logic        len_err
);

   localparam int CNT_W = $clog2(MAX_LEN) + 1;

   localparam logic signed [ACC_W-1:0] c_half = ACC_W'(1) << (FRAC - 1);
   localparam logic signed [ACC_W-1:0] c_max  = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] c_min  = -ACC_W'(32768);

   typedef enum logic [1:0] {
      S_ACCUM = 2'd0,
      S_FLUSH = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   state_t                  r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_bias;
   logic signed [31:0]      r_p;
   logic                    r_p_valid;
   logic                    r_p_last;
   logic [CNT_W-1:0]        r_beat_cnt;

   logic                    w_take;
   logic                    w_last_eff;
   logic signed [31:0]      w_prod;
   logic signed [ACC_W-1:0] w_p_ext;
   logic signed [ACC_W-1:0] w_bias_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_rnd;
   logic [15:0]             w_sat;

   assign in_ready   = rst && (r_state == S_ACCUM);
   assign w_take     = in_valid && in_ready;
   // The beat that fills the vector to MAX_LEN ends it even without in_last.
   assign w_last_eff = in_last || (r_beat_cnt == CNT_W'(MAX_LEN - 1));
   assign w_prod     = $signed(in_x) * $signed(in_w);
   assign w_p_ext    = {{(ACC_W-32){r_p[31]}}, r_p};
   assign w_bias_ext = {{(ACC_W-16){bias[15]}}, bias};

   // Final sum: the last product is still in the pipeline register at flush.
   always_comb begin
      w_sum = r_acc + w_p_ext + r_bias;
      w_rnd = (w_sum + c_half) >>> FRAC;
      w_sat = w_rnd[15:0];
      if (w_rnd > c_max)
         w_sat = 16'h7FFF;
      else if (w_rnd < c_min)
         w_sat = 16'h8000;
   end

   // Multiply stage, accumulate stage and the ACCUM/FLUSH/OUT sequencer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_ACCUM;
         r_acc      <= '0;
         r_bias     <= '0;
         r_p        <= '0;
         r_p_valid  <= 1'b0;
         r_p_last   <= 1'b0;
         r_beat_cnt <= '0;
         out_valid  <= 1'b0;
         out_y      <= '0;
         len_err    <= 1'b0;
      end else begin
         r_p_valid <= w_take;
         if (w_take) begin
            r_p      <= w_prod;
            r_p_last <= w_last_eff;
         end
         // The last product of a vector is folded in by the flush sum instead.
         if (r_p_valid && !r_p_last)
            r_acc <= r_acc + w_p_ext;

         case (r_state)
            S_ACCUM: begin
               if (w_take) begin
                  if (r_beat_cnt == '0)
                     r_bias <= w_bias_ext << FRAC;
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                  if (w_last_eff) begin
                     r_state <= S_FLUSH;
                     if (!in_last)
                        len_err <= 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               out_y     <= w_sat;
               out_valid <= 1'b1;
               r_state   <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  r_acc      <= '0;
                  r_beat_cnt <= '0;
                  r_state    <= S_ACCUM;
               end
            end
            default: r_state <= S_ACCUM;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_q88.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_mac_q88
//  Function : Directed self-checking bench for neuron_mac_q88 (MAX_LEN = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_mac_q88;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_x = '0;
   logic [15:0] in_w = '0;
   logic        in_last = 1'b0;
   logic [15:0] bias = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_y;
   logic        len_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   neuron_mac_q88 #(.FRAC(8), .ACC_W(40), .MAX_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_w      (in_w),
      .in_last   (in_last),
      .bias      (bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   // advance past the next rising edge; inputs change and outputs are sampled here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one beat and hold it until accepted; waited = -1 on timeout
   task automatic send_beat(input logic [15:0] x, input logic [15:0] w,
                            input logic [15:0] b, input logic last,
                            output int waited);
      in_valid = 1'b1; in_x = x; in_w = w; bias = b; in_last = last;
      waited = -1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            waited = i;
            break;
         end
         tick();
      end
      if (waited >= 0) tick();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick(); tick();
      total_cnt++;
      if ({in_ready, out_valid, len_err} !== 3'b000 || out_y !== 16'h0000)
         $display("FAIL reset_state: ready/valid/err=%b out_y=%h, need 000 and 0000",
                  {in_ready, out_valid, len_err}, out_y);
      else pass_cnt++;
      rst = 1'b1;
      tick();
      total_cnt++;
      if (in_ready !== 1'b1)
         $display("FAIL reset_release_ready: in_ready=%b, need 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_single_beat();
      int wt;
      send_beat(16'h0100, 16'h0200, 16'h0080, 1'b1, wt);
      total_cnt++;
      if (wt < 0 || out_valid !== 1'b0)
         $display("FAIL single_early: waited=%0d out_valid=%b, need accept and 0", wt, out_valid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_y !== 16'h0280 || in_ready !== 1'b0)
         $display("FAIL single_result: valid=%b y=%h ready=%b, need 1 0280 0",
                  out_valid, out_y, in_ready);
      else pass_cnt++;
      release_out();
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL single_release: valid=%b ready=%b, need 0 1", out_valid, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int wt;
      int wsum = 0;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         send_beat(16'h0100, 16'h0100, 16'h0000, (i == 3), wt);
         wsum += (wt < 0) ? 100 : wt;
      end
      total_cnt++;
      if (wsum !== 0 || in_ready !== 1'b0)
         $display("FAIL b2b_flow: stall cycles=%0d ready_in_flush=%b, need 0 0", wsum, in_ready);
      else pass_cnt++;
      wait_out(ok);
      total_cnt++;
      if (!ok || out_y !== 16'h0400 || in_ready !== 1'b0 || len_err !== 1'b0)
         $display("FAIL b2b_result: ok=%b y=%h ready=%b err=%b, need 1 0400 0 0",
                  ok, out_y, in_ready, len_err);
      else pass_cnt++;
      release_out();
   endtask

   task automatic test_saturation();
      int wt;
      bit ok;
      send_beat(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, wt);
      send_beat(16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, wt);
      wait_out(ok);
      total_cnt++;
      if (!ok || out_y !== 16'h7FFF)
         $display("FAIL sat_pos: ok=%b y=%h, need 1 7fff", ok, out_y);
      else pass_cnt++;
      release_out();
      send_beat(16'h8000, 16'h7FFF, 16'h0000, 1'b1, wt);
      wait_out(ok);
      total_cnt++;
      if (!ok || out_y !== 16'h8000)
         $display("FAIL sat_neg: ok=%b y=%h, need 1 8000", ok, out_y);
      else pass_cnt++;
      release_out();
   endtask

   task automatic test_rounding();
      logic [15:0] xs [3] = '{16'h0001, 16'h0001, 16'hFFFF};
      logic [15:0] ws [3] = '{16'h0080, 16'h007F, 16'h0080};
      logic [15:0] ys [3] = '{16'h0001, 16'h0000, 16'h0000};
      int wt;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         send_beat(xs[i], ws[i], 16'h0000, 1'b1, wt);
         wait_out(ok);
         total_cnt++;
         if (!ok || out_y !== ys[i])
            $display("FAIL round_%0d: ok=%b y=%h, need 1 %h", i, ok, out_y, ys[i]);
         else pass_cnt++;
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int wt;
      int ready_seen = 0;
      bit ok;
      send_beat(16'h0300, 16'h0100, 16'h0000, 1'b1, wt);
      wait_out(ok);
      // junk beats while the result is held must be ignored
      in_valid = 1'b1; in_x = 16'h7FFF; in_w = 16'h7FFF; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (in_ready) ready_seen++;
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
      total_cnt++;
      if (!ok || out_valid !== 1'b1 || out_y !== 16'h0300 || ready_seen != 0)
         $display("FAIL bp_hold: ok=%b valid=%b y=%h ready_cycles=%0d, need 1 1 0300 0",
                  ok, out_valid, out_y, ready_seen);
      else pass_cnt++;
      release_out();
      send_beat(16'h0200, 16'h0200, 16'h0100, 1'b1, wt);
      wait_out(ok);
      total_cnt++;
      if (!ok || out_y !== 16'h0500)
         $display("FAIL bp_next: ok=%b y=%h, need 1 0500", ok, out_y);
      else pass_cnt++;
      release_out();
   endtask

   task automatic test_len_err_and_reset();
      int wt;
      bit ok;
      for (int i = 0; i < 4; i++)
         send_beat(16'h0100, 16'h0100, 16'h0000, 1'b0, wt);
      wait_out(ok);
      total_cnt++;
      if (!ok || out_y !== 16'h0400 || len_err !== 1'b1)
         $display("FAIL len_forced: ok=%b y=%h err=%b, need 1 0400 1", ok, out_y, len_err);
      else pass_cnt++;
      release_out();
      total_cnt++;
      if (len_err !== 1'b1)
         $display("FAIL len_sticky: err=%b, need 1", len_err);
      else pass_cnt++;
      send_beat(16'h7FFF, 16'h7FFF, 16'h0100, 1'b0, wt);
      send_beat(16'h7FFF, 16'h7FFF, 16'h0100, 1'b0, wt);
      rst = 1'b0;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0)
         $display("FAIL rst_ready: in_ready=%b, need 0", in_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || len_err !== 1'b0)
         $display("FAIL rst_mid: valid=%b err=%b, need 0 0", out_valid, len_err);
      else pass_cnt++;
      rst = 1'b1;
      tick();
      send_beat(16'h0100, 16'h0300, 16'h0000, 1'b1, wt);
      wait_out(ok);
      total_cnt++;
      if (!ok || out_y !== 16'h0300 || len_err !== 1'b0)
         $display("FAIL rst_next: ok=%b y=%h err=%b, need 1 0300 0", ok, out_y, len_err);
      else pass_cnt++;
      release_out();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_len_err_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
